// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: drives one external combinational
// expansion core for NR cycles and keeps the cipher key plus all round keys in a register file.
module aes_key_sched_ctrl #(
  parameter int NR     = 10,
  parameter bit RD_REG = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         clear,
  output logic [127:0] core_key_in,
  output logic [7:0]   core_rcon_index,
  input  logic [127:0] core_key_out,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t       state_r;
  state_t       state_s;
  logic [3:0]   cnt_r;
  logic [127:0] work_r;
  logic [127:0] rk_mem_r [0:NR];
  logic         done_r;
  logic         keys_valid_r;
  logic         accept_s;
  logic         wr_s;
  logic         last_s;
  logic [127:0] rd_sel_s;

  // clear outranks a pending key; key_ready already masks requests during EXPAND
  assign accept_s = key_valid && key_ready && !clear;
  assign wr_s     = (state_r == EXPAND) && !clear;
  assign last_s   = wr_s && (cnt_r == LAST_RND);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, READY: begin
        if (clear)          state_s = IDLE;
        else if (key_valid) state_s = EXPAND;
        else                state_s = state_r;
      end
      EXPAND: begin
        if (clear)                    state_s = IDLE;
        else if (cnt_r == LAST_RND)   state_s = READY;
        else                          state_s = EXPAND;
      end
      default: state_s = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    key_ready       = 1'b1;
    busy            = 1'b0;
    core_rcon_index = 8'h00;
    case (state_r)
      IDLE, READY: begin
        key_ready       = 1'b1;
        busy            = 1'b0;
        core_rcon_index = 8'h00;
      end
      EXPAND: begin
        key_ready       = 1'b0;
        busy            = 1'b1;
        core_rcon_index = {4'h0, cnt_r};
      end
      default: begin
        key_ready       = 1'b1;
        busy            = 1'b0;
        core_rcon_index = 8'h00;
      end
    endcase
  end

  assign core_key_in = work_r;
  assign done        = done_r;
  assign keys_valid  = keys_valid_r;

  // Register file, working key, round counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) rk_mem_r[i] <= 128'h0;
      work_r       <= 128'h0;
      cnt_r        <= 4'd0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
    end else begin
      done_r <= last_s;
      if (clear)         keys_valid_r <= 1'b0;
      else if (last_s)   keys_valid_r <= 1'b1;
      else if (accept_s) keys_valid_r <= 1'b0;
      else               keys_valid_r <= keys_valid_r;
      if (accept_s) begin
        rk_mem_r[0] <= key;
        work_r      <= key;
        cnt_r       <= 4'd1;
      end else if (wr_s) begin
        rk_mem_r[cnt_r] <= core_key_out;
        work_r          <= core_key_out;
        cnt_r           <= cnt_r + 4'd1;
      end else begin
        work_r <= work_r;
        cnt_r  <= cnt_r;
      end
    end
  end

  // Read mux; addresses beyond the last round key read as zero
  always_comb begin
    rd_sel_s = 128'h0;
    if (rk_addr <= LAST_RND) rd_sel_s = rk_mem_r[rk_addr];
    else                     rd_sel_s = 128'h0;
  end

  generate
    if (RD_REG) begin : g_rd_reg
      logic [127:0] rk_data_r;
      // Registered read: sampled before any same-edge write lands
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rk_data_r <= 128'h0;
        else        rk_data_r <= rd_sel_s;
      end
      assign rk_data = rk_data_r;
    end else begin : g_rd_comb
      assign rk_data = rd_sel_s;
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: a behavioural AES-128 expansion core feeds two
// controllers (combinational and registered read port) sharing all inputs.
module tb_aes_key_sched_ctrl;

  typedef logic [10:0][127:0] sched_t;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_A     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B     = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] KEY_C     = 128'h5a5a5a5aa5a5a5a53c3c3c3cc3c3c3c3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic         key_valid;
  logic         clear;
  logic [3:0]   rk_addr;

  logic         key_ready, busy, done, keys_valid;
  logic [127:0] core_key_in, core_key_out, rk_data;
  logic [7:0]   core_rcon_index;
  logic         r1_key_ready, r1_busy, r1_done, r1_keys_valid;
  logic [127:0] r1_core_key_in, r1_core_key_out, r1_rk_data;
  logic [7:0]   r1_core_rcon_index;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0]   rcon_q [$];
  logic [127:0] rd_q   [$];

  always #10 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, e;
    e = 8'hfe; inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (e[i]) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] idx);
    logic [31:0] w0, w1, w2, w3, rot, t;
    logic [7:0]  rc;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    rc = 8'h01;
    for (int i = 1; i < int'(idx); i++) rc = gmul(rc, 8'h02);
    t  = t ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic sched_t make_sched(input logic [127:0] k);
    sched_t s;
    s[0] = k;
    for (int r = 1; r <= 10; r++) s[r] = expand_key(s[r-1], 8'(r));
    return s;
  endfunction

  assign core_key_out    = expand_key(core_key_in, core_rcon_index);
  assign r1_core_key_out = expand_key(r1_core_key_in, r1_core_rcon_index);

  aes_key_sched_ctrl #(.NR(10), .RD_REG(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .clear(clear), .core_key_in(core_key_in), .core_rcon_index(core_rcon_index),
    .core_key_out(core_key_out), .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_addr(rk_addr), .rk_data(rk_data)
  );

  aes_key_sched_ctrl #(.NR(10), .RD_REG(1'b1)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .key_ready(r1_key_ready),
    .clear(clear), .core_key_in(r1_core_key_in), .core_rcon_index(r1_core_rcon_index),
    .core_key_out(r1_core_key_out), .busy(r1_busy), .done(r1_done), .keys_valid(r1_keys_valid),
    .rk_addr(rk_addr), .rk_data(r1_rk_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] k);
    key = k; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key = 128'h0; key_valid = 1'b0; clear = 1'b0; rk_addr = 4'd0;
    #15;
    chk_cnt++; if (key_ready !== 1'b1) $display("FAIL rst_key_ready got %b want 1", key_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (keys_valid !== 1'b0) $display("FAIL rst_keys_valid got %b want 0", keys_valid); else pass_cnt++;
    chk_cnt++; if (core_rcon_index !== 8'h00) $display("FAIL rst_rcon got %h want 00", core_rcon_index); else pass_cnt++;
    chk_cnt++; if (rk_data !== 128'h0) $display("FAIL rst_rk_data got %h want 0", rk_data); else pass_cnt++;
    chk_cnt++; if (r1_rk_data !== 128'h0) $display("FAIL rst_r1_rk_data got %h want 0", r1_rk_data); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips();
    sched_t s;
    logic [7:0] exp8;
    logic [127:0] exp128;
    s = make_sched(FIPS_KEY);
    for (int r = 1; r <= 10; r++) rcon_q.push_back(8'(r));
    accept(FIPS_KEY);
    for (int c = 1; c <= 10; c++) begin
      exp8 = rcon_q.pop_front();
      chk_cnt++; if (busy !== 1'b1) $display("FAIL fips_busy c%0d got %b want 1", c, busy); else pass_cnt++;
      chk_cnt++; if (key_ready !== 1'b0) $display("FAIL fips_key_ready c%0d got %b want 0", c, key_ready); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0 || keys_valid !== 1'b0) $display("FAIL fips_early_done c%0d got %b%b want 00", c, done, keys_valid); else pass_cnt++;
      chk_cnt++; if (core_rcon_index !== exp8) $display("FAIL fips_rcon c%0d got %h want %h", c, core_rcon_index, exp8); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (done !== 1'b1) $display("FAIL fips_done got %b want 1", done); else pass_cnt++;
    chk_cnt++; if (keys_valid !== 1'b1) $display("FAIL fips_keys_valid got %b want 1", keys_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || key_ready !== 1'b1) $display("FAIL fips_idle_flags busy=%b ready=%b want 0/1", busy, key_ready); else pass_cnt++;
    chk_cnt++; if (core_rcon_index !== 8'h00) $display("FAIL fips_rcon_after got %h want 00", core_rcon_index); else pass_cnt++;
    for (int a = 0; a <= 10; a++) rd_q.push_back(s[a]);
    for (int a = 0; a <= 10; a++) begin
      rk_addr = 4'(a);
      #1;
      exp128 = rd_q.pop_front();
      chk_cnt++; if (rk_data !== exp128) $display("FAIL fips_entry%0d got %h want %h", a, rk_data, exp128); else pass_cnt++;
    end
    rk_addr = 4'd1; #0.5;
    chk_cnt++; if (rk_data !== FIPS_RK1) $display("FAIL fips_rk1_const got %h want %h", rk_data, FIPS_RK1); else pass_cnt++;
    rk_addr = 4'd10; #0.5;
    chk_cnt++; if (rk_data !== FIPS_RK10) $display("FAIL fips_rk10_const got %h want %h", rk_data, FIPS_RK10); else pass_cnt++;
    tick();
    chk_cnt++; if (done !== 1'b0) $display("FAIL fips_done_width got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (keys_valid !== 1'b1) $display("FAIL fips_keys_valid_hold got %b want 1", keys_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    sched_t sa, sb;
    logic [7:0] exp8;
    logic [127:0] exp128;
    sa = make_sched(KEY_A);
    sb = make_sched(KEY_B);
    for (int r = 1; r <= 10; r++) rcon_q.push_back(8'(r));
    key = KEY_A; key_valid = 1'b1;
    tick();
    key = KEY_B;
    for (int c = 1; c <= 10; c++) begin
      exp8 = rcon_q.pop_front();
      chk_cnt++; if (key_ready !== 1'b0) $display("FAIL b2b_key_ready c%0d got %b want 0", c, key_ready); else pass_cnt++;
      chk_cnt++; if (core_rcon_index !== exp8) $display("FAIL b2b_rcon c%0d got %h want %h", c, core_rcon_index, exp8); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (done !== 1'b1 || key_ready !== 1'b1) $display("FAIL b2b_first_ready done=%b ready=%b want 1/1", done, key_ready); else pass_cnt++;
    for (int a = 0; a <= 10; a++) rd_q.push_back(sa[a]);
    for (int a = 0; a <= 10; a++) begin
      rk_addr = 4'(a);
      #1;
      exp128 = rd_q.pop_front();
      chk_cnt++; if (rk_data !== exp128) $display("FAIL b2b_entry_a%0d got %h want %h", a, rk_data, exp128); else pass_cnt++;
    end
    tick();
    key_valid = 1'b0;
    chk_cnt++; if (busy !== 1'b1 || keys_valid !== 1'b0 || done !== 1'b0) $display("FAIL b2b_restart busy=%b kv=%b done=%b want 1/0/0", busy, keys_valid, done); else pass_cnt++;
    chk_cnt++; if (core_rcon_index !== 8'h01) $display("FAIL b2b_restart_rcon got %h want 01", core_rcon_index); else pass_cnt++;
    for (int c = 0; c < 10; c++) tick();
    chk_cnt++; if (done !== 1'b1 || keys_valid !== 1'b1) $display("FAIL b2b_done_b done=%b kv=%b want 1/1", done, keys_valid); else pass_cnt++;
    for (int a = 0; a <= 10; a++) rd_q.push_back(sb[a]);
    for (int a = 0; a <= 10; a++) begin
      rk_addr = 4'(a);
      #1;
      exp128 = rd_q.pop_front();
      chk_cnt++; if (rk_data !== exp128) $display("FAIL b2b_entry_b%0d got %h want %h", a, rk_data, exp128); else pass_cnt++;
    end
  endtask

  task automatic test_clear();
    sched_t sb, sc;
    logic [127:0] exp128;
    sb = make_sched(KEY_B);
    sc = make_sched(KEY_C);
    accept(KEY_C);
    for (int c = 1; c < 5; c++) tick();
    chk_cnt++; if (core_rcon_index !== 8'h05) $display("FAIL clr_at_cycle5 got %h want 05", core_rcon_index); else pass_cnt++;
    clear = 1'b1; key_valid = 1'b1;
    tick();
    clear = 1'b0; key_valid = 1'b0;
    chk_cnt++; if (busy !== 1'b0 || key_ready !== 1'b1) $display("FAIL clr_idle busy=%b ready=%b want 0/1", busy, key_ready); else pass_cnt++;
    chk_cnt++; if (keys_valid !== 1'b0 || done !== 1'b0) $display("FAIL clr_flags kv=%b done=%b want 0/0", keys_valid, done); else pass_cnt++;
    chk_cnt++; if (core_rcon_index !== 8'h00) $display("FAIL clr_rcon got %h want 00", core_rcon_index); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL clr_no_done c%0d done=%b busy=%b want 0/0", c, done, busy); else pass_cnt++;
    end
    for (int a = 0; a <= 10; a++) rd_q.push_back((a < 5) ? sc[a] : sb[a]);
    for (int a = 0; a <= 10; a++) begin
      rk_addr = 4'(a);
      #1;
      exp128 = rd_q.pop_front();
      chk_cnt++; if (rk_data !== exp128) $display("FAIL clr_entry%0d got %h want %h", a, rk_data, exp128); else pass_cnt++;
    end
    tick();
    clear = 1'b1; key = KEY_A; key_valid = 1'b1;
    tick();
    clear = 1'b0; key_valid = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL clr_priority busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    accept(FIPS_KEY);
    for (int c = 1; c < 4; c++) tick();
    rk_addr = 4'd1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (key_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rmid_ready_busy ready=%b busy=%b want 1/0", key_ready, busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0 || keys_valid !== 1'b0) $display("FAIL rmid_flags done=%b kv=%b want 0/0", done, keys_valid); else pass_cnt++;
    chk_cnt++; if (core_rcon_index !== 8'h00) $display("FAIL rmid_rcon got %h want 00", core_rcon_index); else pass_cnt++;
    chk_cnt++; if (rk_data !== 128'h0 || r1_rk_data !== 128'h0) $display("FAIL rmid_rk_data got %h/%h want 0", rk_data, r1_rk_data); else pass_cnt++;
    #2;
    rst_n = 1'b1;
    tick();
    test_fips();
  endtask

  task automatic test_rd_reg();
    sched_t s;
    logic [127:0] exp128, prev, got;
    s = make_sched(FIPS_KEY);
    rk_addr = 4'd0;
    tick();
    prev = s[0];
    for (int a = 0; a <= 15; a++) begin
      exp128 = (a <= 10) ? s[a] : 128'h0;
      rk_addr = 4'(a);
      rd_q.push_back(exp128);
      #1;
      chk_cnt++; if (rk_data !== exp128) $display("FAIL rd_comb a%0d got %h want %h", a, rk_data, exp128); else pass_cnt++;
      chk_cnt++; if (r1_rk_data !== prev) $display("FAIL rd_reg_lag a%0d got %h want %h", a, r1_rk_data, prev); else pass_cnt++;
      tick();
      got = rd_q.pop_front();
      chk_cnt++; if (r1_rk_data !== got) $display("FAIL rd_reg a%0d got %h want %h", a, r1_rk_data, got); else pass_cnt++;
      prev = got;
    end
    rk_addr = 4'd0;
    rd_q.push_back(s[0]);
    key = KEY_A; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    got = rd_q.pop_front();
    chk_cnt++; if (r1_rk_data !== got) $display("FAIL rd_before_write got %h want %h", r1_rk_data, got); else pass_cnt++;
    chk_cnt++; if (rk_data !== KEY_A) $display("FAIL rd_new_entry0 got %h want %h", rk_data, KEY_A); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_rd_reg();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
